ber_accumulator: RTL and testbench

- Sits directly downstream of the per-word bit comparator.
- Consumes the comparator's per-word mismatch count (0..13 errored bits per 13-bit word) with a valid strobe.
- Accumulates errored bits, received bits and received words over a measurement window, and flags loss of pattern sync.
- Presents counts to the readout/display logic, which computes the BER ratio.

---
 rtl/ber_accumulator.sv | 186 ++++++++++++++++++
 tb/tb_ber_accumulator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ber_accumulator.sv
// ber_accumulator
//   Accumulates the per-word mismatch counts from the bit comparator over a
//   measurement window. It keeps errored-bit, compared-bit and word totals,
//   and flags loss of pattern sync. The readout logic uses these counts to
//   form the BER ratio.
//
// Ports
//   clk, rst_n     : clock and asynchronous active-low reset
//   start          : begin a measurement (honoured in IDLE or DONE)
//   stop           : end the measurement early (honoured in RUN)
//   clear          : abort, zero everything, return to IDLE (highest priority)
//   word_valid     : per-word strobe qualifying err_in
//   err_in         : errored-bit count of the current word
//   window_words   : words per measurement, 0 = unlimited, sampled on start
//   busy           : high while measuring
//   done           : one-cycle pulse on entry to DONE
//   err_cnt        : accumulated errored bits (saturating)
//   bit_cnt        : accumulated compared bits (saturating)
//   word_cnt       : accumulated words (saturating)
//   err_sat        : sticky, some counter reached all-ones
//   in_range_err   : sticky, an err_in above WORD_W was received
//   sync_lost      : sticky, SYNC_LOSS_N consecutive bad words were seen
module ber_accumulator #(
    parameter int WORD_W      = 13,
    parameter int ERR_W       = 32,
    parameter int BIT_W       = 48,
    parameter int WCNT_W      = 32,
    parameter int SYNC_THRESH = 7,
    parameter int SYNC_LOSS_N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] err_in,
    input  logic [WCNT_W-1:0] window_words,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic [WCNT_W-1:0] word_cnt,
    output logic              err_sat,
    output logic              in_range_err,
    output logic              sync_lost
);

    localparam int RUN_W  = $clog2(SYNC_LOSS_N + 1);
    // The error sum must be wide enough for both operands plus a carry, even
    // in narrow builds where ERR_W is smaller than WORD_W.
    localparam int ESUM_W = ((ERR_W > WORD_W) ? ERR_W : WORD_W) + 1;

    localparam logic [WORD_W-1:0] WORD_MAX = WORD_W'(WORD_W);
    localparam logic [WORD_W-1:0] THRESH   = WORD_W'(SYNC_THRESH);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(SYNC_LOSS_N);
    localparam logic [ERR_W-1:0]  ERR_ONES = {ERR_W{1'b1}};
    localparam logic [BIT_W-1:0]  BIT_ONES = {BIT_W{1'b1}};
    localparam logic [WCNT_W-1:0] WRD_ONES = {WCNT_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WCNT_W-1:0] word_q, word_d;
    logic [WCNT_W-1:0] win_q, win_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              err_sat_q, err_sat_d;
    logic              range_q, range_d;
    logic              sync_q, sync_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Clamp the incoming count; a value above WORD_W indicates an upstream fault.
    logic              over_range;
    logic [WORD_W-1:0] e_clamp;
    logic              bad_word;
    assign over_range = (err_in > WORD_MAX);
    assign e_clamp    = over_range ? WORD_MAX : err_in;
    assign bad_word   = (e_clamp >= THRESH);

    // Saturating next values. Each counter holds at all-ones.
    logic [ESUM_W-1:0] err_sum;
    logic [BIT_W:0]    bit_sum;
    logic [WCNT_W:0]   word_sum;
    logic [ERR_W-1:0]  err_next;
    logic [BIT_W-1:0]  bit_next;
    logic [WCNT_W-1:0] word_next;
    logic [RUN_W-1:0]  run_inc;

    assign err_sum   = ESUM_W'(err_q) + ESUM_W'(e_clamp);
    assign err_next  = (err_sum > ESUM_W'(ERR_ONES)) ? ERR_ONES : err_sum[ERR_W-1:0];
    assign bit_sum   = {1'b0, bit_q} + (BIT_W+1)'(WORD_W);
    assign bit_next  = bit_sum[BIT_W] ? BIT_ONES : bit_sum[BIT_W-1:0];
    assign word_sum  = {1'b0, word_q} + {{WCNT_W{1'b0}}, 1'b1};
    assign word_next = word_sum[WCNT_W] ? WRD_ONES : word_sum[WCNT_W-1:0];
    assign run_inc   = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;

    // clear beats everything; start only acts outside RUN, so stop and start
    // never compete for the same state.
    logic do_clear, do_start;
    assign do_clear = clear;
    assign do_start = !clear && start && (state_q != S_RUN);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        bit_d     = bit_q;
        word_d    = word_q;
        win_d     = win_q;
        run_d     = run_q;
        err_sat_d = err_sat_q;
        range_d   = range_q;
        sync_d    = sync_q;

        if (state_q == S_RUN) begin
            if (word_valid) begin
                err_d  = err_next;
                bit_d  = bit_next;
                word_d = word_next;
                if (over_range) range_d = 1'b1;
                if ((err_next == ERR_ONES) || (bit_next == BIT_ONES) ||
                    (word_next == WRD_ONES)) err_sat_d = 1'b1;
                run_d = bad_word ? run_inc : '0;
                if (bad_word && (run_inc == RUN_MAX)) sync_d = 1'b1;
                // Window completes on the same edge that commits its last word.
                if ((win_q != '0) && (word_next == win_q)) state_d = S_DONE;
            end
            if (stop) state_d = S_DONE;
        end

        if (do_clear || do_start) begin
            err_d     = '0;
            bit_d     = '0;
            word_d    = '0;
            run_d     = '0;
            err_sat_d = 1'b0;
            range_d   = 1'b0;
            sync_d    = 1'b0;
            win_d     = do_clear ? '0 : window_words;
            state_d   = do_clear ? S_IDLE : S_RUN;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            err_q     <= '0;
            bit_q     <= '0;
            word_q    <= '0;
            win_q     <= '0;
            run_q     <= '0;
            err_sat_q <= 1'b0;
            range_q   <= 1'b0;
            sync_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            bit_q     <= bit_d;
            word_q    <= word_d;
            win_q     <= win_d;
            run_q     <= run_d;
            err_sat_q <= err_sat_d;
            range_q   <= range_d;
            sync_q    <= sync_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err_cnt      = err_q;
    assign bit_cnt      = bit_q;
    assign word_cnt     = word_q;
    assign err_sat      = err_sat_q;
    assign in_range_err = range_q;
    assign sync_lost    = sync_q;

endmodule

// File: tb/tb_ber_accumulator.sv
`timescale 1ns/1ps
// Directed bench for ber_accumulator: a default build plus an ERR_W=4 build
// for saturation.
module tb_ber_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start, stop, clear, word_valid;
    logic [12:0] err_in;
    logic [31:0] window_words;
    logic        busy, done, err_sat, in_range_err, sync_lost;
    logic [31:0] err_cnt;
    logic [47:0] bit_cnt;
    logic [31:0] word_cnt;

    logic        s_start, s_wv;
    logic [12:0] s_err;
    logic        s_busy, s_done, s_err_sat, s_range, s_sync;
    logic [3:0]  s_err_cnt;
    logic [47:0] s_bit_cnt;
    logic [31:0] s_word_cnt;
    logic        s_stop, s_clear;
    logic [31:0] s_win;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    ber_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .word_valid(word_valid), .err_in(err_in), .window_words(window_words),
        .busy(busy), .done(done), .err_cnt(err_cnt), .bit_cnt(bit_cnt),
        .word_cnt(word_cnt), .err_sat(err_sat), .in_range_err(in_range_err),
        .sync_lost(sync_lost)
    );

    ber_accumulator #(.ERR_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop), .clear(s_clear),
        .word_valid(s_wv), .err_in(s_err), .window_words(s_win),
        .busy(s_busy), .done(s_done), .err_cnt(s_err_cnt), .bit_cnt(s_bit_cnt),
        .word_cnt(s_word_cnt), .err_sat(s_err_sat), .in_range_err(s_range),
        .sync_lost(s_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done is registered; at the rising edge it still shows the previous cycle's value.
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic strobe(input logic [12:0] e);
        @(negedge clk); word_valid = 1'b1; err_in = e;
        @(negedge clk); word_valid = 1'b0; err_in = '0;
    endtask

    task automatic pulse_start(input logic [31:0] w);
        @(negedge clk); start = 1'b1; window_words = w;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0d want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0d want 0", done); end
        n_chk++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", err_cnt); end
        n_chk++; if (bit_cnt !== 48'd0) begin n_fail++; $display("FAIL reset_bit got %0d want 0", bit_cnt); end
        n_chk++; if (word_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_word got %0d want 0", word_cnt); end
        n_chk++; if ({err_sat, in_range_err, sync_lost} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {err_sat, in_range_err, sync_lost}); end
        @(negedge clk); rst_n = 1'b1;
        strobe(13'd5);
        n_chk++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL idle_ignore got %0d want 0", err_cnt); end
    endtask

    task automatic test_window();
        int base;
        base = done_cnt;
        pulse_start(32'd4);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL win_busy got %0d want 1", busy); end
        strobe(13'd0); strobe(13'd1); strobe(13'd2);
        n_chk++; if (word_cnt !== 32'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL win_mid word %0d busy %0d want 3 1", word_cnt, busy); end
        strobe(13'd3);
        n_chk++; if (err_cnt !== 32'd6) begin n_fail++; $display("FAIL win_err got %0d want 6", err_cnt); end
        n_chk++; if (bit_cnt !== 48'd52) begin n_fail++; $display("FAIL win_bit got %0d want 52", bit_cnt); end
        n_chk++; if (word_cnt !== 32'd4) begin n_fail++; $display("FAIL win_word got %0d want 4", word_cnt); end
        n_chk++; if (busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL win_end busy %0d done %0d want 0 1", busy, done); end
        @(negedge clk);
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL win_done_pulse got %0d want 0", done); end
        repeat (2) @(negedge clk);
        n_chk++; if (done_cnt !== base + 1) begin n_fail++; $display("FAIL win_done_count got %0d want %0d", done_cnt, base + 1); end
    endtask

    task automatic test_unlimited();
        pulse_start(32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); word_valid = 1'b1; err_in = 13'd13;
        end
        @(negedge clk); word_valid = 1'b0; err_in = '0;
        n_chk++; if (word_cnt !== 32'd10 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL unl_run word %0d busy %0d done %0d want 10 1 0", word_cnt, busy, done); end
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        n_chk++; if (err_cnt !== 32'd130) begin n_fail++; $display("FAIL unl_err got %0d want 130", err_cnt); end
        n_chk++; if (bit_cnt !== 48'd130) begin n_fail++; $display("FAIL unl_bit got %0d want 130", bit_cnt); end
        n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL unl_stop done %0d busy %0d want 1 0", done, busy); end
    endtask

    task automatic test_range();
        pulse_start(32'd0);
        strobe(13'd20);
        n_chk++; if (err_cnt !== 32'd13 || in_range_err !== 1'b1) begin n_fail++; $display("FAIL range_clamp err %0d flag %0d want 13 1", err_cnt, in_range_err); end
        strobe(13'd1);
        n_chk++; if (err_cnt !== 32'd14 || in_range_err !== 1'b1) begin n_fail++; $display("FAIL range_sticky err %0d flag %0d want 14 1", err_cnt, in_range_err); end
        pulse_stop();
        n_chk++; if (in_range_err !== 1'b1) begin n_fail++; $display("FAIL range_done got %0d want 1", in_range_err); end
        pulse_start(32'd0);
        n_chk++; if (in_range_err !== 1'b0 || err_cnt !== 32'd0) begin n_fail++; $display("FAIL range_restart flag %0d err %0d want 0 0", in_range_err, err_cnt); end
        pulse_stop();
    endtask

    task automatic test_sync();
        logic [12:0] pat [8] = '{13'd7, 13'd7, 13'd7, 13'd2, 13'd7, 13'd7, 13'd7, 13'd7};
        logic        exp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        pulse_start(32'd0);
        for (int i = 0; i < 8; i++) begin
            strobe(pat[i]);
            n_chk++; if (sync_lost !== exp[i]) begin n_fail++; $display("FAIL sync_word%0d got %0d want %0d", i + 1, sync_lost, exp[i]); end
        end
        n_chk++; if (err_cnt !== 32'd51) begin n_fail++; $display("FAIL sync_err got %0d want 51", err_cnt); end
        strobe(13'd0);
        n_chk++; if (sync_lost !== 1'b1 || word_cnt !== 32'd9) begin n_fail++; $display("FAIL sync_hold flag %0d word %0d want 1 9", sync_lost, word_cnt); end
        pulse_stop();
    endtask

    task automatic test_back_to_back();
        @(negedge clk); start = 1'b1; clear = 1'b1;
        @(negedge clk); start = 1'b0; clear = 1'b0;
        n_chk++; if (busy !== 1'b0 || err_cnt !== 32'd0 || word_cnt !== 32'd0 || sync_lost !== 1'b0) begin n_fail++; $display("FAIL clr_start busy %0d err %0d word %0d sync %0d want 0 0 0 0", busy, err_cnt, word_cnt, sync_lost); end
        strobe(13'd3);
        n_chk++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_idle err got %0d want 0", err_cnt); end
        pulse_start(32'd0);
        strobe(13'd4);
        @(negedge clk); start = 1'b1; word_valid = 1'b1; err_in = 13'd6;
        @(negedge clk); start = 1'b0; word_valid = 1'b0; err_in = '0;
        n_chk++; if (err_cnt !== 32'd10 || word_cnt !== 32'd2) begin n_fail++; $display("FAIL run_start_ignored err %0d word %0d want 10 2", err_cnt, word_cnt); end
        stop = 1'b1; word_valid = 1'b1; err_in = 13'd5;
        @(negedge clk); stop = 1'b0; word_valid = 1'b0; err_in = '0;
        n_chk++; if (err_cnt !== 32'd15 || word_cnt !== 32'd3) begin n_fail++; $display("FAIL stop_word err %0d word %0d want 15 3", err_cnt, word_cnt); end
        n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_done done %0d busy %0d want 1 0", done, busy); end
        strobe(13'd2);
        n_chk++; if (err_cnt !== 32'd15) begin n_fail++; $display("FAIL done_hold err got %0d want 15", err_cnt); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_e [3] = '{4'd13, 4'd15, 4'd15};
        logic       exp_s [3] = '{1'b0, 1'b1, 1'b1};
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); s_wv = 1'b1; s_err = 13'd13;
            @(negedge clk); s_wv = 1'b0; s_err = '0;
            n_chk++; if (s_err_cnt !== exp_e[i]) begin n_fail++; $display("FAIL sat_err%0d got %0d want %0d", i, s_err_cnt, exp_e[i]); end
            n_chk++; if (s_err_sat !== exp_s[i]) begin n_fail++; $display("FAIL sat_flag%0d got %0d want %0d", i, s_err_sat, exp_s[i]); end
        end
        n_chk++; if (s_bit_cnt !== 48'd39 || s_word_cnt !== 32'd3) begin n_fail++; $display("FAIL sat_others bit %0d word %0d want 39 3", s_bit_cnt, s_word_cnt); end
    endtask

    task automatic test_async_reset();
        int base;
        pulse_start(32'd0);
        strobe(13'd9); strobe(13'd9);
        n_chk++; if (err_cnt !== 32'd18 || busy !== 1'b1) begin n_fail++; $display("FAIL ares_pre err %0d busy %0d want 18 1", err_cnt, busy); end
        base = done_cnt;
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || err_cnt !== 32'd0 || bit_cnt !== 48'd0 || word_cnt !== 32'd0) begin n_fail++; $display("FAIL ares_async busy %0d done %0d err %0d bit %0d word %0d want all 0", busy, done, err_cnt, bit_cnt, word_cnt); end
        n_chk++; if (s_err_cnt !== 4'd0 || s_err_sat !== 1'b0) begin n_fail++; $display("FAIL ares_sat err %0d flag %0d want 0 0", s_err_cnt, s_err_sat); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (done_cnt !== base || busy !== 1'b0) begin n_fail++; $display("FAIL ares_nodone count %0d busy %0d want %0d 0", done_cnt, busy, base); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        word_valid = 1'b0; err_in = '0; window_words = '0;
        s_start = 1'b0; s_stop = 1'b0; s_clear = 1'b0; s_wv = 1'b0;
        s_err = '0; s_win = '0;
        test_reset();
        test_window();
        test_unlimited();
        test_range();
        test_sync();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
